rp_acq_trig_ctrl: RTL and testbench
===================================

// Module: rp_acq_trig_ctrl
// PURPOSE
// Acquisition trigger controller, downstream of the per-channel ADC threshold triggers.
// - Selects one trigger source from the channel threshold pulses, the external pulses or a manual trigger.
// - Runs the arm / pre-trigger / wait / post-trigger sequence.
// - Generates the capture write enable and a wrapping buffer write pointer.
// - Latches the write pointer at the trigger instant, so software can locate the trigger sample.
// PARAMETERS
// AW   14  buffer address width; write pointer wraps modulo 2**AW
// CW   32  width of pre-trigger and post-trigger delay counters
// PORTS
// adc_clk_i     in   1    ADC clock; all logic on rising edge
// adc_rst_i     in   1    asynchronous reset, active high
// adc_dv_i      in   1    sample valid strobe, qualifies all sample counting
// arm_i         in   1    1-cycle request: start acquisition
// abort_i       in   1    1-cycle request: stop and return to IDLE
// trig_sel_i    in   3    source: 0 none, 1 manual, 2 A+, 3 A-, 4 B+, 5 B-, 6 ext+, 7 ext-
// trig_man_i    in   1    manual trigger pulse
// trig_a_p_i    in   1    ch A rising-threshold pulse (1 cycle)
// trig_a_n_i    in   1    ch A falling-threshold pulse
// trig_b_p_i    in   1    ch B rising-threshold pulse
// trig_b_n_i    in   1    ch B falling-threshold pulse
// trig_ext_p_i  in   1    external rising-edge pulse
// trig_ext_n_i  in   1    external falling-edge pulse
// pre_cnt_i     in   CW   valid samples required before a trigger is accepted
// post_dly_i    in   CW   valid samples captured after the trigger
// acq_we_o      out  1    buffer write enable
// acq_wp_o      out  AW   buffer write pointer
// trig_wp_o     out  AW   write pointer latched at the accepted trigger
// trig_o        out  1    1-cycle pulse on the accepted trigger
// state_o       out  3    0 IDLE, 1 PRE, 2 WAIT, 3 POST, 4 DONE
// done_o        out  1    high while in DONE
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE, all counters 0, acq_wp_o=0, trig_wp_o=0, all outputs 0.
// - trig_sel_i, pre_cnt_i and post_dly_i are sampled on the accepted arm.
//   - Changes during an acquisition are ignored.
// - Selected trigger = mux(sampled sel) of the inputs. Sel 0 never triggers.
// - IDLE:
//   - arm_i goes to PRE.
//   - The pre counter is cleared. acq_wp_o is kept, not reset.
// - PRE:
//   - The pre counter increments on each adc_dv_i.
//   - Move to WAIT on the cycle the count reaches pre_cnt. If pre_cnt=0, go to WAIT the cycle after arm.
//   - Triggers in PRE are discarded.
// - WAIT:
//   - The first selected trigger pulse is accepted. No adc_dv_i qualification is applied.
//   - Next cycle: trig_o=1, trig_wp_o=acq_wp_o value at the trigger cycle, state POST, post counter loaded with post_dly.
//   - If post_dly=0, go to DONE instead of POST.
// - POST:
//   - The post counter decrements on adc_dv_i.
//   - Go to DONE on the cycle it reaches 0. Further triggers are ignored.
// - DONE:
//   - Hold until arm_i (goes to PRE) or abort_i (goes to IDLE).
// - acq_we_o = adc_dv_i && state in {PRE, WAIT, POST}; combinational, zero latency.
// - acq_wp_o increments by 1 on every cycle with acq_we_o=1, and wraps 2**AW-1 to 0 with no flag.
// - Priority: abort_i > arm_i > trigger.
//   - abort_i in any state: IDLE next cycle, with no trig_o.
//   - abort_i and arm_i together: IDLE.
//   - arm_i in PRE, WAIT or POST is ignored. arm_i in DONE restarts.
//   - A trigger on the same cycle as abort_i is dropped.
// - A trigger and the PRE completion on the same cycle: the trigger is discarded.
// - Counter arithmetic is unsigned CW bits. The pre counter saturates at 2**CW-1 and does not wrap.
// TESTING
// - pre=4, post=3, sel=2, dv constant: A+ pulse 2 cycles after WAIT -> trig_o 1 cycle later; 3 further writes; DONE; trig_wp_o = pointer at trigger.
// - A+ pulse during PRE, then A+ pulse in WAIT -> first ignored, trig_wp_o from the second.
// - sel=1, pre=0, post=0: arm, manual pulse -> DONE the cycle after the trigger; exactly 1 trig_o.
// - dv toggling 1/0, pre=3 -> WAIT entered after 3 valid samples (6 clocks); acq_we_o mirrors dv.
// - AW=4: 20 writes -> acq_wp_o wraps 15->0 and ends at 4.
// - Abort in POST with a simultaneous trigger and arm -> IDLE, no trig_o, acq_we_o 0; async reset mid-POST -> all outputs 0 immediately.

Source files
------------

// File: rtl/rp_acq_trig_ctrl.sv
// Acquisition trigger controller: source select, arm/pre/wait/post
// sequencing, capture write enable and wrapping buffer write pointer.
module rp_acq_trig_ctrl #(
  parameter int AW = 14,
  parameter int CW = 32
) (
  input  logic          adc_clk_i,
  input  logic          adc_rst_i,
  input  logic          adc_dv_i,
  input  logic          arm_i,
  input  logic          abort_i,
  input  logic [2:0]    trig_sel_i,
  input  logic          trig_man_i,
  input  logic          trig_a_p_i,
  input  logic          trig_a_n_i,
  input  logic          trig_b_p_i,
  input  logic          trig_b_n_i,
  input  logic          trig_ext_p_i,
  input  logic          trig_ext_n_i,
  input  logic [CW-1:0] pre_cnt_i,
  input  logic [CW-1:0] post_dly_i,
  output logic          acq_we_o,
  output logic [AW-1:0] acq_wp_o,
  output logic [AW-1:0] trig_wp_o,
  output logic          trig_o,
  output logic [2:0]    state_o,
  output logic          done_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_sel;
  logic [CW-1:0] r_pre;
  logic [CW-1:0] r_post;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_pre_inc;
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_trig_wp;
  logic          r_trig;
  logic          w_trig_sel;
  logic          w_arm_ok;
  logic          w_accept;
  logic          w_we;

  // Trigger source mux, driven by the selection captured at arm
  always_comb begin
    w_trig_sel = 1'b0;
    case (r_sel)
      3'd1:    w_trig_sel = trig_man_i;
      3'd2:    w_trig_sel = trig_a_p_i;
      3'd3:    w_trig_sel = trig_a_n_i;
      3'd4:    w_trig_sel = trig_b_p_i;
      3'd5:    w_trig_sel = trig_b_n_i;
      3'd6:    w_trig_sel = trig_ext_p_i;
      3'd7:    w_trig_sel = trig_ext_n_i;
      default: w_trig_sel = 1'b0;
    endcase
  end

  assign w_we = adc_dv_i &&
    (r_state == S_PRE || r_state == S_WAIT || r_state == S_POST);

  assign w_arm_ok = arm_i && !abort_i &&
    (r_state == S_IDLE || r_state == S_DONE);

  assign w_accept = (r_state == S_WAIT) && w_trig_sel && !abort_i;

  // Pre-trigger count saturates instead of wrapping
  assign w_pre_inc = (adc_dv_i && r_cnt != {CW{1'b1}}) ?
    r_cnt + CW'(1) : r_cnt;

  // Next-state and sample counter update
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (abort_i) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (arm_i) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (pre_cnt_i == '0) ? S_WAIT : S_PRE;
          end
        end
        S_PRE: begin
          w_cnt_nxt = w_pre_inc;
          if (w_pre_inc >= r_pre) w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (w_accept) begin
            w_cnt_nxt   = r_post;
            w_state_nxt = (r_post == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (adc_dv_i) begin
            w_cnt_nxt = r_cnt - CW'(1);
            if (r_cnt <= CW'(1)) w_state_nxt = S_DONE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, counters, pointers and configuration capture
  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sel     <= '0;
      r_pre     <= '0;
      r_post    <= '0;
      r_wp      <= '0;
      r_trig_wp <= '0;
      r_trig    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_trig  <= w_accept;
      if (w_we) r_wp <= r_wp + AW'(1);
      if (w_accept) r_trig_wp <= r_wp;
      if (w_arm_ok) begin
        r_sel  <= trig_sel_i;
        r_pre  <= pre_cnt_i;
        r_post <= post_dly_i;
      end
    end
  end

  assign acq_we_o  = w_we;
  assign acq_wp_o  = r_wp;
  assign trig_wp_o = r_trig_wp;
  assign trig_o    = r_trig;
  assign state_o   = r_state;
  assign done_o    = (r_state == S_DONE);

endmodule

// File: tb/tb_rp_acq_trig_ctrl.sv
// Scoreboard bench for rp_acq_trig_ctrl: random and directed stimulus
// checked against a behavioural model of the acquisition sequence.
module tb_rp_acq_trig_ctrl;

  localparam int AW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dv = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [2:0]    sel = '0;
  logic [6:0]    trg = '0;
  logic [CW-1:0] pre = '0;
  logic [CW-1:0] post = '0;
  logic          we;
  logic [AW-1:0] wp;
  logic [AW-1:0] twp;
  logic          trig;
  logic [2:0]    st;
  logic          done;

  rp_acq_trig_ctrl #(.AW(AW), .CW(CW)) dut (
    .adc_clk_i   (clk),
    .adc_rst_i   (rst),
    .adc_dv_i    (dv),
    .arm_i       (arm),
    .abort_i     (abort),
    .trig_sel_i  (sel),
    .trig_man_i  (trg[0]),
    .trig_a_p_i  (trg[1]),
    .trig_a_n_i  (trg[2]),
    .trig_b_p_i  (trg[3]),
    .trig_b_n_i  (trg[4]),
    .trig_ext_p_i(trg[5]),
    .trig_ext_n_i(trg[6]),
    .pre_cnt_i   (pre),
    .post_dly_i  (post),
    .acq_we_o    (we),
    .acq_wp_o    (wp),
    .trig_wp_o   (twp),
    .trig_o      (trig),
    .state_o     (st),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int we;
    int wp;
    int twp;
    int trig;
    int st;
    int done;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int n_chk = 0;
  int n_fail = 0;

  // Model: phase 0 idle,1 pre,2 wait,3 post,4 done
  int m_mode = 0;
  int m_sel = 0;
  int m_pre = 0;
  int m_post = 0;
  int m_seen = 0;
  int m_left = 0;
  int m_wp = 0;
  int m_twp = 0;
  int m_trig = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        me = q.pop_front();
        chk("acq_we", int'(we), me.we);
        chk("acq_wp", int'(wp), me.wp);
        chk("trig_wp", int'(twp), me.twp);
        chk("trig_o", int'(trig), me.trig);
        chk("state", int'(st), me.st);
        chk("done", int'(done), me.done);
      end
    end
  end

  task automatic cyc(input logic i_dv, input logic i_arm,
                     input logic i_abort, input logic [2:0] i_sel,
                     input logic [6:0] i_trg, input int i_pre,
                     input int i_post);
    exp_t e;
    logic [7:0] tv;
    int hit;
    int nt;
    @(posedge clk);
    #2;
    dv = i_dv;
    arm = i_arm;
    abort = i_abort;
    sel = i_sel;
    trg = i_trg;
    pre = CW'(i_pre);
    post = CW'(i_post);
    e.we = (i_dv && m_mode >= 1 && m_mode <= 3) ? 1 : 0;
    e.wp = m_wp;
    e.twp = m_twp;
    e.trig = m_trig;
    e.st = m_mode;
    e.done = (m_mode == 4) ? 1 : 0;
    q.push_back(e);
    tv = {i_trg, 1'b0};
    hit = int'(tv[m_sel]);
    nt = 0;
    if (i_abort) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0, 4: if (i_arm) begin
          m_sel = int'(i_sel);
          m_pre = i_pre;
          m_post = i_post;
          m_seen = 0;
          m_mode = (i_pre == 0) ? 2 : 1;
        end
        1: begin
          if (i_dv) m_seen++;
          if (m_seen >= m_pre) m_mode = 2;
        end
        2: if (hit != 0) begin
          m_twp = m_wp;
          nt = 1;
          m_left = m_post;
          m_mode = (m_post == 0) ? 4 : 3;
        end
        3: if (i_dv) begin
          m_left--;
          if (m_left == 0) m_mode = 4;
        end
        default: m_mode = 0;
      endcase
    end
    if (e.we != 0) m_wp = (m_wp + 1) % (1 << AW);
    m_trig = nt;
  endtask

  // Idle-ish cycle with junk config inputs that must be ignored
  task automatic run(input logic i_dv, input logic [6:0] i_trg);
    cyc(i_dv, 1'b0, 1'b0, 3'($urandom_range(0, 7)), i_trg,
        $urandom_range(0, 6), $urandom_range(0, 5));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, int'(we), 0);
    chk({tag, "_wp"}, int'(wp), 0);
    chk({tag, "_twp"}, int'(twp), 0);
    chk({tag, "_trig"}, int'(trig), 0);
    chk({tag, "_state"}, int'(st), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    logic [6:0] rt;
    #3;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // sel A+, pre 4, post 3, A+ in PRE ignored, A+ in WAIT accepted
    cyc(1'b1, 1'b1, 1'b0, 3'd2, 7'd0, 4, 3);
    run(1'b1, 7'd0);
    run(1'b1, 7'b0000010);
    run(1'b1, 7'd0);
    run(1'b1, 7'd0);
    run(1'b1, 7'd0);
    run(1'b1, 7'd0);
    run(1'b1, 7'b0000010);
    for (int i = 0; i < 6; i++) run(1'b1, 7'b0000010);
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 7'd0, 0, 0);

    // manual, pre 0, post 0
    cyc(1'b1, 1'b1, 1'b0, 3'd1, 7'd0, 0, 0);
    run(1'b1, 7'b0000001);
    for (int i = 0; i < 3; i++) run(1'b1, 7'b0000001);
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 7'd0, 0, 0);

    // dv toggling, pre 3, never triggers
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 7'd0, 3, 2);
    for (int i = 0; i < 8; i++) run(i[0] == 1'b0, 7'b1111111);
    cyc(1'b1, 1'b0, 1'b1, 3'd0, 7'd0, 0, 0);

    // abort in POST with trigger and arm together
    cyc(1'b1, 1'b1, 1'b0, 3'd6, 7'd0, 1, 10);
    run(1'b1, 7'd0);
    run(1'b1, 7'b0100000);
    run(1'b1, 7'd0);
    cyc(1'b1, 1'b1, 1'b1, 3'd6, 7'b0100000, 0, 3);
    run(1'b1, 7'b0100000);
    run(1'b1, 7'd0);

    // long run for pointer wrap, then reset mid-POST
    cyc(1'b1, 1'b1, 1'b0, 3'd1, 7'd0, 0, 6);
    run(1'b1, 7'b0000001);
    run(1'b1, 7'd0);
    run(1'b1, 7'd0);
    drain();
    @(posedge clk);
    #2;
    dv = 1'b1;
    arm = 1'b0;
    abort = 1'b0;
    trg = '0;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    m_mode = 0;
    m_wp = 0;
    m_twp = 0;
    m_trig = 0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 7; k++) rt[k] = ($urandom_range(0, 7) == 0);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 59) == 0, 3'($urandom_range(0, 7)), rt,
          $urandom_range(0, 6), $urandom_range(0, 5));
    end
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
